ysyx_22041071_axi_rd_arb: RTL and testbench

Two-master arbiter that shares the single AXI read-channel master between the instruction-fetch unit (IFU, requester 0) and the load/store unit (LSU, requester 1). It accepts read requests from both, grants one at a time by round-robin, and drives the read engine's CPU-side request port. It routes returned beats back to the granted requester and guards each transaction with a watchdog. The block sits between the pipeline's IF/MEM stages and the AXI read engine.

---
 rtl/ysyx_22041071_axi_rd_arb.sv | 210 +++++++++++++++++++++
 tb/tb_ysyx_22041071_axi_rd_arb.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041071_axi_rd_arb.sv
// Round-robin arbiter that shares one AXI read engine between the IFU (req0) and the LSU (req1).
// It routes returned beats to the granted requester and guards each transaction with a watchdog.
module ysyx_22041071_axi_rd_arb #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [1:0]        req0_size,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  output logic [1:0]        req0_rresp,
  output logic              req0_rlast,

  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [1:0]        req1_size,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [1:0]        req1_rresp,
  output logic              req1_rlast,

  output logic              rd_valid,
  output logic [ID_W-1:0]   rd_id,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_size,
  output logic [LEN_W-1:0]  rd_len,
  input  logic              rd_ready,
  input  logic              rd_r_valid,
  input  logic [DATA_W-1:0] rd_r_data,
  input  logic [1:0]        rd_r_resp,
  input  logic              rd_r_last
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic                        last_gnt_q, last_gnt_d;
  logic                        gnt_q, gnt_d;
  logic                        rd_valid_q, rd_valid_d;
  logic [ID_W-1:0]             rd_id_q, rd_id_d;
  logic [ADDR_W-1:0]           rd_addr_q, rd_addr_d;
  logic [1:0]                  rd_size_q, rd_size_d;
  logic [LEN_W-1:0]            rd_len_q, rd_len_d;
  logic [LEN_W-1:0]            beat_cnt_q, beat_cnt_d;
  logic [WD_W-1:0]             wd_cnt_q, wd_cnt_d;
  logic [1:0]                  ready_q, ready_d;
  logic [1:0]                  rvalid_q, rvalid_d;
  logic [1:0]                  rlast_q, rlast_d;
  logic [1:0][1:0]             rresp_q, rresp_d;
  logic [1:0][DATA_W-1:0]      rdata_q, rdata_d;
  logic                        win;
  logic                        wd_hit;

  assign wd_hit = (wd_cnt_q == WD_W'(TIMEOUT - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    rd_valid_d = rd_valid_q;
    rd_id_d    = rd_id_q;
    rd_addr_d  = rd_addr_q;
    rd_size_d  = rd_size_q;
    rd_len_d   = rd_len_q;
    beat_cnt_d = beat_cnt_q;
    wd_cnt_d   = wd_cnt_q;
    ready_d    = '0;
    rvalid_d   = '0;
    rlast_d    = '0;
    rresp_d    = '0;
    rdata_d    = '0;
    win        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the requester that did not win last time goes first
          win        = (req0_valid && req1_valid) ? ~last_gnt_q : req1_valid;
          gnt_d      = win;
          last_gnt_d = win;
          rd_id_d    = ID_W'(win);
          rd_addr_d  = win ? req1_addr : req0_addr;
          rd_size_d  = win ? req1_size : req0_size;
          rd_len_d   = win ? req1_len  : req0_len;
          ready_d[win] = 1'b1;
          rd_valid_d = 1'b1;
          beat_cnt_d = '0;
          wd_cnt_d   = '0;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (wd_hit) begin
          rvalid_d[gnt_q] = 1'b1;
          rlast_d[gnt_q]  = 1'b1;
          rresp_d[gnt_q]  = 2'b10;
          rd_valid_d      = 1'b0;
          state_d         = S_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
          if (rd_ready) begin
            rd_valid_d = 1'b0;
            state_d    = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (wd_hit) begin
          rvalid_d[gnt_q] = 1'b1;
          rlast_d[gnt_q]  = 1'b1;
          rresp_d[gnt_q]  = 2'b10;
          rd_valid_d      = 1'b0;
          state_d         = S_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
          if (rd_r_valid) begin
            rvalid_d[gnt_q] = 1'b1;
            rdata_d[gnt_q]  = rd_r_data;
            rresp_d[gnt_q]  = rd_r_resp;
            // The latched length bounds the burst even if the engine never flags last
            if (rd_r_last || (beat_cnt_q == rd_len_q)) begin
              rlast_d[gnt_q] = 1'b1;
              state_d        = S_IDLE;
            end else begin
              beat_cnt_d = beat_cnt_q + LEN_W'(1);
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      rd_addr_q  <= '0;
      rd_size_q  <= '0;
      rd_len_q   <= '0;
      beat_cnt_q <= '0;
      wd_cnt_q   <= '0;
      ready_q    <= '0;
      rvalid_q   <= '0;
      rlast_q    <= '0;
      rresp_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      rd_addr_q  <= rd_addr_d;
      rd_size_q  <= rd_size_d;
      rd_len_q   <= rd_len_d;
      beat_cnt_q <= beat_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      ready_q    <= ready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_id       = rd_id_q;
  assign rd_addr     = rd_addr_q;
  assign rd_size     = rd_size_q;
  assign rd_len      = rd_len_q;

  assign req0_ready  = ready_q[0];
  assign req0_rvalid = rvalid_q[0];
  assign req0_rdata  = rdata_q[0];
  assign req0_rresp  = rresp_q[0];
  assign req0_rlast  = rlast_q[0];

  assign req1_ready  = ready_q[1];
  assign req1_rvalid = rvalid_q[1];
  assign req1_rdata  = rdata_q[1];
  assign req1_rresp  = rresp_q[1];
  assign req1_rlast  = rlast_q[1];

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
// Scoreboard bench for the two-master AXI read arbiter: grants and beats are predicted
// when stimulus is driven and popped when the arbiter produces them.
module tb_ysyx_22041071_axi_rd_arb;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [1:0]        req0_size, req1_size;
  logic [LEN_W-1:0]  req0_len, req1_len;
  logic              req0_ready, req1_ready;
  logic              req0_rvalid, req1_rvalid;
  logic [DATA_W-1:0] req0_rdata, req1_rdata;
  logic [1:0]        req0_rresp, req1_rresp;
  logic              req0_rlast, req1_rlast;
  logic              rd_valid;
  logic [ID_W-1:0]   rd_id;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_size;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_ready;
  logic              rd_r_valid;
  logic [DATA_W-1:0] rd_r_data;
  logic [1:0]        rd_r_resp;
  logic              rd_r_last;

  typedef struct packed { bit req; logic [63:0] addr; logic [1:0] size; logic [7:0] len; } gnt_t;
  typedef struct packed { bit req; logic [63:0] data; logic [1:0] resp; bit last; } beat_t;

  gnt_t  gnt_q[$];
  beat_t beat_q[$];
  int    n_total = 0;
  int    n_bad   = 0;

  ysyx_22041071_axi_rd_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_size(req0_size), .req0_len(req0_len),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req0_rresp(req0_rresp), .req0_rlast(req0_rlast),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_size(req1_size), .req1_len(req1_len),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .req1_rresp(req1_rresp), .req1_rlast(req1_rlast),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_addr(rd_addr), .rd_size(rd_size), .rd_len(rd_len),
    .rd_ready(rd_ready), .rd_r_valid(rd_r_valid), .rd_r_data(rd_r_data),
    .rd_r_resp(rd_r_resp), .rd_r_last(rd_r_last)
  );

  // Pops predicted grants/beats whenever the arbiter emits one
  task automatic scoreboard();
    gnt_t         g;
    beat_t        b;
    logic [80:0]  got_g, exp_g;
    logic [135:0] got_b, exp_b;
    forever begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        n_total++;
        got_g = {req1_ready, req0_ready, rd_valid, rd_id, rd_size, rd_len, rd_addr};
        if (gnt_q.size() == 0) begin
          n_bad++;
          $display("FAIL grant: unexpected grant got=%h required none", got_g);
        end else begin
          g = gnt_q.pop_front();
          exp_g = {g.req, ~g.req, 1'b1, 4'(g.req), g.size, g.len, g.addr};
          if (got_g !== exp_g) begin
            n_bad++;
            $display("FAIL grant: got=%h required=%h", got_g, exp_g);
          end
        end
      end
      if (req0_rvalid || req1_rvalid) begin
        n_total++;
        got_b = {req1_rvalid, req1_rlast, req1_rresp, req1_rdata,
                 req0_rvalid, req0_rlast, req0_rresp, req0_rdata};
        if (beat_q.size() == 0) begin
          n_bad++;
          $display("FAIL beat: unexpected beat got=%h required none", got_b);
        end else begin
          b = beat_q.pop_front();
          exp_b = '0;
          if (b.req) exp_b[135:68] = {1'b1, b.last, b.resp, b.data};
          else       exp_b[67:0]   = {1'b1, b.last, b.resp, b.data};
          if (got_b !== exp_b) begin
            n_bad++;
            $display("FAIL beat: got=%h required=%h", got_b, exp_b);
          end
        end
      end
    end
  endtask

  task automatic wait_ready(input bit who, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((who ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [1:0] r, input bit l);
    rd_r_valid = 1'b1; rd_r_data = d; rd_r_resp = r; rd_r_last = l;
    @(posedge clk); #1;
    rd_r_valid = 1'b0; rd_r_data = '0; rd_r_resp = '0; rd_r_last = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (gnt_q.size() == 0 && beat_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({rd_valid, rd_id, rd_addr, rd_size, rd_len,
         req0_ready, req0_rvalid, req0_rdata, req0_rresp, req0_rlast,
         req1_ready, req1_rvalid, req1_rdata, req1_rresp, req1_rlast} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rd_valid=%b rd_id=%h rd_addr=%h r0=%b r1=%b, required all 0",
               rd_valid, rd_id, rd_addr, req0_rvalid, req1_rvalid);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_single_ifu();
    bit ok;
    rd_ready = 1'b1;
    gnt_q.push_back('{1'b0, 64'h8000_0004, 2'b10, 8'd0});
    beat_q.push_back('{1'b0, 64'h1122334455667788, 2'b00, 1'b1});
    req0_addr = 64'h8000_0004; req0_size = 2'b10; req0_len = 8'd0; req0_valid = 1'b1;
    wait_ready(1'b0, ok);
    n_total++;
    if (!ok) begin n_bad++; $display("FAIL single_ready: req0_ready not seen, required a pulse"); end
    req0_valid = 1'b0;
    n_total++;
    if ({req0_ready, rd_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL single_pulse: ready=%b rd_valid=%b after handshake, required 0 0", req0_ready, rd_valid);
    end
    send_beat(64'h1122334455667788, 2'b00, 1'b1);
    wait_drain(ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL single_drain: pending grants=%0d beats=%0d, required 0", gnt_q.size(), beat_q.size());
      gnt_q.delete(); beat_q.delete();
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [15:0] ids;
    ids = '0;
    rd_ready = 1'b1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    req0_addr = 64'h1000; req0_size = 2'b10; req0_len = 8'd0;
    req1_addr = 64'h2000; req1_size = 2'b11; req1_len = 8'd0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) gnt_q.push_back('{1'b0, 64'h1000, 2'b10, 8'd0});
      else            gnt_q.push_back('{1'b1, 64'h2000, 2'b11, 8'd0});
      beat_q.push_back('{bit'(i % 2), 64'hA0 + 64'(i), 2'b00, 1'b1});
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin ok = 1'b1; ids = {ids[11:0], rd_id}; break; end
      end
      n_total++;
      if (!ok) begin n_bad++; $display("FAIL rr_grant%0d: no grant seen, required one", i); end
      @(posedge clk); #1;
      send_beat(64'hA0 + 64'(i), 2'b00, 1'b1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_total++;
    if (ids !== 16'h0101) begin n_bad++; $display("FAIL rr_order: rd_id seq=%h required 0101", ids); end
    wait_drain(ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rr_drain: pending grants=%0d beats=%0d, required 0", gnt_q.size(), beat_q.size());
      gnt_q.delete(); beat_q.delete();
    end
  endtask

  task automatic test_burst();
    bit ok;
    rd_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      gnt_q.push_back('{1'b1, 64'h3000, 2'b11, 8'd3});
      for (int k = 1; k <= 4; k++)
        beat_q.push_back('{1'b1, 64'(k), (k == 2) ? 2'b01 : 2'b00, k == 4});
      req1_addr = 64'h3000; req1_size = 2'b11; req1_len = 8'd3; req1_valid = 1'b1;
      wait_ready(1'b1, ok);
      n_total++;
      if (!ok) begin n_bad++; $display("FAIL burst%0d_ready: req1_ready not seen, required a pulse", v); end
      req1_valid = 1'b0;
      for (int k = 1; k <= 4; k++)
        send_beat(64'(k), (k == 2) ? 2'b01 : 2'b00, (v == 0) && (k == 4));
      // A beat arriving after completion must be dropped
      if (v == 1) send_beat(64'd5, 2'b00, 1'b1);
      wait_drain(ok);
      n_total++;
      if (!ok) begin
        n_bad++;
        $display("FAIL burst%0d_drain: pending grants=%0d beats=%0d, required 0", v, gnt_q.size(), beat_q.size());
        gnt_q.delete(); beat_q.delete();
      end
    end
  endtask

  task automatic test_issue_stall();
    bit ok;
    logic [78:0] got;
    rd_ready = 1'b0;
    gnt_q.push_back('{1'b0, 64'h4000_0010, 2'b01, 8'd1});
    beat_q.push_back('{1'b0, 64'h55, 2'b00, 1'b0});
    beat_q.push_back('{1'b0, 64'h66, 2'b00, 1'b1});
    req0_addr = 64'h4000_0010; req0_size = 2'b01; req0_len = 8'd1; req0_valid = 1'b1;
    wait_ready(1'b0, ok);
    n_total++;
    if (!ok) begin n_bad++; $display("FAIL stall_ready: req0_ready not seen, required a pulse"); end
    req0_valid = 1'b0; req0_addr = '1; req0_size = 2'b11; req0_len = 8'hff;
    for (int i = 0; i < 5; i++) begin
      rd_r_valid = (i == 2); rd_r_data = 64'hdead; rd_r_last = (i == 2);
      @(negedge clk);
      got = {rd_valid, rd_id, rd_size, rd_len, rd_addr};
      n_total++;
      if (got !== {1'b1, 4'd0, 2'b01, 8'd1, 64'h4000_0010}) begin
        n_bad++;
        $display("FAIL stall_hold%0d: got=%h required=%h", i, got, {1'b1, 4'd0, 2'b01, 8'd1, 64'h4000_0010});
      end
      @(posedge clk); #1;
    end
    rd_r_valid = 1'b0; rd_r_data = '0; rd_r_last = 1'b0;
    rd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drop: rd_valid=%b after handshake, required 0", rd_valid); end
    @(posedge clk); #1;
    send_beat(64'h55, 2'b00, 1'b0);
    send_beat(64'h66, 2'b00, 1'b1);
    wait_drain(ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL stall_drain: pending grants=%0d beats=%0d, required 0", gnt_q.size(), beat_q.size());
      gnt_q.delete(); beat_q.delete();
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int gap;
    for (int v = 0; v < 2; v++) begin
      rd_ready = (v == 0);
      if (v == 0) begin
        gnt_q.push_back('{1'b1, 64'h7000, 2'b11, 8'd0});
        beat_q.push_back('{1'b1, 64'h0, 2'b10, 1'b1});
        req1_addr = 64'h7000; req1_size = 2'b11; req1_len = 8'd0; req1_valid = 1'b1;
      end else begin
        gnt_q.push_back('{1'b0, 64'h7100, 2'b10, 8'd0});
        beat_q.push_back('{1'b0, 64'h0, 2'b10, 1'b1});
        req0_addr = 64'h7100; req0_size = 2'b10; req0_len = 8'd0; req0_valid = 1'b1;
      end
      ok = 1'b0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin ok = 1'b1; break; end
      end
      n_total++;
      if (!ok) begin n_bad++; $display("FAIL timeout%0d_ready: no grant seen, required one", v); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      gap = 0;
      for (int j = 1; j <= 40; j++) begin
        @(negedge clk);
        if (req0_rvalid || req1_rvalid) begin gap = j; break; end
      end
      n_total++;
      if (gap != 16 || rd_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout%0d_beat: cycles=%0d rd_valid=%b, required 16 and 0", v, gap, rd_valid);
      end
      @(posedge clk); #1;
      wait_drain(ok);
      n_total++;
      if (!ok) begin
        n_bad++;
        $display("FAIL timeout%0d_drain: pending grants=%0d beats=%0d, required 0", v, gnt_q.size(), beat_q.size());
        gnt_q.delete(); beat_q.delete();
      end
    end
    rd_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    rd_ready = 1'b1;
    gnt_q.push_back('{1'b0, 64'h5000, 2'b11, 8'd3});
    beat_q.push_back('{1'b0, 64'h77, 2'b00, 1'b0});
    req0_addr = 64'h5000; req0_size = 2'b11; req0_len = 8'd3; req0_valid = 1'b1;
    wait_ready(1'b0, ok);
    n_total++;
    if (!ok) begin n_bad++; $display("FAIL rmid_ready: req0_ready not seen, required a pulse"); end
    req0_valid = 1'b0;
    send_beat(64'h77, 2'b00, 1'b0);
    reset_n = 1'b0;
    rd_r_valid = 1'b1; rd_r_data = 64'h99; rd_r_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({rd_valid, rd_id, rd_addr, rd_size, rd_len,
         req0_ready, req0_rvalid, req0_rdata, req0_rresp, req0_rlast,
         req1_ready, req1_rvalid, req1_rdata, req1_rresp, req1_rlast} !== '0) begin
      n_bad++;
      $display("FAIL rmid_outputs: got rd_valid=%b rd_addr=%h r0=%b r1=%b, required all 0",
               rd_valid, rd_addr, req0_rvalid, req1_rvalid);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    rd_r_valid = 1'b0; rd_r_data = '0; rd_r_last = 1'b0;
    gnt_q.push_back('{1'b0, 64'h6000, 2'b10, 8'd0});
    beat_q.push_back('{1'b0, 64'h88, 2'b00, 1'b1});
    req0_addr = 64'h6000; req0_size = 2'b10; req0_len = 8'd0;
    req1_addr = 64'h6100; req1_size = 2'b11; req1_len = 8'd0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_ready(1'b0, ok);
    n_total++;
    if (!ok) begin n_bad++; $display("FAIL rmid_tie: req0_ready not seen after reset, required IFU grant"); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    send_beat(64'h88, 2'b00, 1'b1);
    wait_drain(ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rmid_drain: pending grants=%0d beats=%0d, required 0", gnt_q.size(), beat_q.size());
      gnt_q.delete(); beat_q.delete();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_size = '0; req0_len = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_size = '0; req1_len = '0;
    rd_ready = 1'b1; rd_r_valid = 1'b0; rd_r_data = '0; rd_r_resp = '0; rd_r_last = 1'b0;
    test_reset();
    fork
      scoreboard();
    join_none
    test_single_ifu();
    test_round_robin();
    test_burst();
    test_issue_stall();
    test_timeout();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
